// File: rtl/a5_1_stream_decipher_if.sv
// Byte-stream bundle for the A5/1 stream decipher: ciphertext in, plaintext out.
// The master side produces ciphertext and consumes plaintext; the slave is the decipher.
interface a5_1_stream_decipher_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/a5_1_stream_decipher.sv
// A5/1 stream decipher: regenerates the keystream from key/frame and XORs it
// onto incoming ciphertext bytes, one byte per valid/ready transfer.
// A frame is: 64 key-loading steps, 22 frame-loading steps, MIX_CYCLES
// discarded majority steps, then FRAME_BYTES keystream bytes (MSB first).
module a5_1_stream_decipher #(
    parameter int FRAME_BYTES = 28,
    parameter int MIX_CYCLES  = 100
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [63:0]             key,
    input  logic [21:0]             frame,
    a5_1_stream_decipher_if.slave   bus,
    output logic                    busy,
    output logic                    done
);

    localparam int CW = $clog2(((MIX_CYCLES > 64) ? MIX_CYCLES : 64) + 1);
    localparam int BW = $clog2(FRAME_BYTES + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_KEY,
        LOAD_FRAME,
        MIX,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic [18:0]     r1;
    logic [21:0]     r2;
    logic [22:0]     r3;
    logic [63:0]     key_sh;
    logic [21:0]     frame_sh;
    logic [CW-1:0]   step_cnt;

    logic [BW-1:0]   byte_cnt;
    logic [2:0]      bit_cnt;
    logic [7:0]      ks_byte;
    logic            ks_full;
    logic            out_valid_q;
    logic [7:0]      out_data_q;
    logic            in_ready_c;

    logic            start_ok;
    logic            phase_end;
    logic            xfer;
    logic            out_accept;
    logic            frame_end;
    logic            loading;
    logic            gen;
    logic            stepping;
    logic            load_bit;
    logic            maj;
    logic            ks_bit;
    logic            step1;
    logic            step2;
    logic            step3;
    logic            fb1;
    logic            fb2;
    logic            fb3;

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    // Handshake and phase-boundary qualifiers shared by the FSM and datapath
    always_comb begin
        start_ok   = start && ((state == IDLE) || (state == DONE));
        xfer       = bus.in_valid && in_ready_c;
        out_accept = out_valid_q && bus.out_ready;
        frame_end  = (state == RUN) && (byte_cnt == BW'(FRAME_BYTES)) && out_accept;
        phase_end  = 1'b0;
        case (state)
            LOAD_KEY:   phase_end = (step_cnt == CW'(63));
            LOAD_FRAME: phase_end = (step_cnt == CW'(21));
            MIX:        phase_end = (step_cnt == CW'(MIX_CYCLES - 1));
            default:    phase_end = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: loading phases are counted, RUN ends when the last byte leaves
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start_ok)  state_nxt = LOAD_KEY;
            LOAD_KEY:   if (phase_end) state_nxt = LOAD_FRAME;
            LOAD_FRAME: if (phase_end) state_nxt = MIX;
            MIX:        if (phase_end) state_nxt = RUN;
            RUN:        if (frame_end) state_nxt = DONE;
            DONE:       if (start_ok)  state_nxt = LOAD_KEY;
            default:    state_nxt = IDLE;
        endcase
    end

    // FSM outputs: busy covers the whole frame, in_ready needs a full keystream byte and room downstream
    always_comb begin
        busy       = (state == LOAD_KEY) || (state == LOAD_FRAME) ||
                     (state == MIX) || (state == RUN);
        in_ready_c = (state == RUN) && ks_full && (!out_valid_q || bus.out_ready);
    end

    // Step control: loading clocks every register, otherwise majority clocking applies
    always_comb begin
        loading  = (state == LOAD_KEY) || (state == LOAD_FRAME);
        gen      = (state == RUN) && !ks_full && (byte_cnt < BW'(FRAME_BYTES));
        stepping = loading || (state == MIX) || gen;
        load_bit = 1'b0;
        if (state == LOAD_KEY) begin
            load_bit = key_sh[0];
        end else if (state == LOAD_FRAME) begin
            load_bit = frame_sh[0];
        end
        maj    = (r1[8] & r2[10]) | (r1[8] & r3[10]) | (r2[10] & r3[10]);
        step1  = loading || (r1[8]  == maj);
        step2  = loading || (r2[10] == maj);
        step3  = loading || (r3[10] == maj);
        fb1    = r1[13] ^ r1[16] ^ r1[17] ^ r1[18] ^ load_bit;
        fb2    = r2[20] ^ r2[21] ^ load_bit;
        fb3    = r3[7] ^ r3[20] ^ r3[21] ^ r3[22] ^ load_bit;
        ks_bit = r1[18] ^ r2[21] ^ r3[22];
    end

    // LFSRs, key/frame shifters and the phase step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            key_sh   <= '0;
            frame_sh <= '0;
            step_cnt <= '0;
        end else if (start_ok) begin
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            key_sh   <= key;
            frame_sh <= frame;
            step_cnt <= '0;
        end else begin
            if (stepping) begin
                if (step1) r1 <= {r1[17:0], fb1};
                if (step2) r2 <= {r2[20:0], fb2};
                if (step3) r3 <= {r3[21:0], fb3};
            end
            if (state == LOAD_KEY) begin
                key_sh <= {1'b0, key_sh[63:1]};
            end
            if (state == LOAD_FRAME) begin
                frame_sh <= {1'b0, frame_sh[21:1]};
            end
            if (loading || (state == MIX)) begin
                step_cnt <= phase_end ? '0 : step_cnt + CW'(1);
            end
        end
    end

    // Keystream byte assembly, byte transfer and the plaintext output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt    <= '0;
            bit_cnt     <= '0;
            ks_byte     <= '0;
            ks_full     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done        <= 1'b0;
        end else begin
            done <= frame_end;
            if (start_ok) begin
                byte_cnt    <= '0;
                bit_cnt     <= '0;
                ks_byte     <= '0;
                ks_full     <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                if (gen) begin
                    ks_byte <= {ks_byte[6:0], ks_bit};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        ks_full <= 1'b1;
                    end
                end
                if (xfer) begin
                    out_data_q  <= bus.in_data ^ ks_byte;
                    out_valid_q <= 1'b1;
                    ks_full     <= 1'b0;
                    byte_cnt    <= byte_cnt + BW'(1);
                end else if (out_accept) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

endmodule
